// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: address map, read-only flags and FSM encoding for the APB register bridge
package apb_reg_pkg;

   localparam logic [3:0] ADDR_DATA0    = 4'h0;
   localparam logic [3:0] ADDR_DATA0_SR = 4'h4;
   localparam logic [3:0] ADDR_DATA1    = 4'h8;
   localparam logic [3:0] ADDR_DATA1_SR = 4'hC;

   // Bit n set means the register at word index n (addr[3:2]) is read-only.
   localparam logic [3:0] RO_MAP = 4'b1010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   function automatic logic is_ro(input logic [1:0] idx);
      return RO_MAP[idx];
   endfunction

endpackage

// File: rtl/apb_reg_addr_dec.sv
// apb_reg_addr_dec: flags unmapped, misaligned or read-only-write accesses
// Ports:
//   addr_i  - latched register-side address
//   write_i - latched direction, 1 = write
//   err_o   - 1 when the access must be refused
module apb_reg_addr_dec
   import apb_reg_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic [AW-1:0] addr_i,
   input  logic          write_i,
   output logic          err_o
);

   logic hit;

   assign hit = (addr_i == AW'(ADDR_DATA0))    || (addr_i == AW'(ADDR_DATA0_SR)) ||
                (addr_i == AW'(ADDR_DATA1))    || (addr_i == AW'(ADDR_DATA1_SR));

   // Misaligned addresses never match the map, so one hit test covers both cases.
   assign err_o = !hit || (write_i && is_ro(addr_i[3:2]));

endmodule

// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB slave to single-cycle register strobe bridge with fixed 3-cycle latency
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   psel/penable/pwrite   - APB control
//   paddr/pwdata          - APB address and write data
//   pready/prdata/pslverr - APB response (prdata registered)
//   wr_en/rd_en           - one-cycle register-side strobes
//   addr/wdata            - latched register-side address and write data
//   rdata                 - combinational register-side read data
// Build option: APB_REG_BRIDGE_PSLVERR_EN enables address decoding and pslverr.
module apb_reg_bridge
   import apb_reg_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          psel,
   input  logic          penable,
   input  logic          pwrite,
   input  logic [AW-1:0] paddr,
   input  logic [DW-1:0] pwdata,
   output logic          pready,
   output logic [DW-1:0] prdata,
   output logic          pslverr,
   output logic          wr_en,
   output logic          rd_en,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   input  logic [DW-1:0] rdata
);

   state_e        state_q, state_d;
   logic          write_q, write_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] prdata_q, prdata_d;
   logic          err;

`ifdef APB_REG_BRIDGE_PSLVERR_EN
   apb_reg_addr_dec #(.AW(AW)) u_dec (
      .addr_i  (addr_q),
      .write_i (write_q),
      .err_o   (err)
   );
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         prdata_q <= prdata_d;
      end
   end

   // Only the setup phase is captured; psel=1 with penable=1 in IDLE is ignored.
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      prdata_d = prdata_q;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               write_d = pwrite;
               addr_d  = paddr;
               wdata_d = pwdata;
            end
         end
         ACCESS: begin
            state_d  = RESP;
            prdata_d = (write_q || err) ? '0 : rdata;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign wr_en   = (state_q == ACCESS) && write_q && !err;
   assign rd_en   = (state_q == ACCESS) && !write_q && !err;
   assign pready  = (state_q == RESP);
   assign pslverr = pready && err;
   assign prdata  = prdata_q;
   assign addr    = addr_q;
   assign wdata   = wdata_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge: directed self-checking bench for apb_reg_bridge
module tb_apb_reg_bridge;

   localparam int DW = 32;
   localparam int AW = 10;
`ifdef APB_REG_BRIDGE_PSLVERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverr;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   int checks = 0;
   int failures = 0;

   apb_reg_bridge #(.DW(DW), .AW(AW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called one time unit after a rising edge (cycle 0); returns at cycle 3 with the bus idle.
   task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
      logic [DW-1:0] exp_prd;
      exp_prd = (wr || err) ? '0 : rd;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; rdata = rd;
      @(negedge clk);
      check({tag, "_c0_strb"}, DW'({wr_en, rd_en}), DW'(2'b00));
      check({tag, "_c0_rdy"}, DW'(pready), '0);
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk);
      check({tag, "_c1_strb"}, DW'({wr_en, rd_en}), DW'({wr & ~err, ~wr & ~err}));
      check({tag, "_c1_addr"}, DW'(addr), DW'(a));
      check({tag, "_c1_wdata"}, wdata, wd);
      check({tag, "_c1_rdy"}, DW'(pready), '0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_c2_rdy"}, DW'(pready), DW'(1'b1));
      check({tag, "_c2_err"}, DW'(pslverr), DW'(err));
      check({tag, "_c2_prdata"}, prdata, exp_prd);
      check({tag, "_c2_strb"}, DW'({wr_en, rd_en}), '0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic idle_check(input string tag, input logic [DW-1:0] exp_prd);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check({tag, "_rdy"}, DW'({pready, pslverr}), '0);
      check({tag, "_prdata"}, prdata, exp_prd);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; rdata = '0;
      #12;
      check("rst_ctrl", DW'({pready, pslverr, wr_en, rd_en}), '0);
      check("rst_prdata", prdata, '0);
      check("rst_addr", DW'(addr), '0);
      check("rst_wdata", wdata, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      xfer("wr0", 1'b1, 10'h000, 32'hDEADBEEF, 32'h0, 1'b0);
      xfer("rd8", 1'b0, 10'h008, 32'h0, 32'hFFFFFFFF, 1'b0);
      idle_check("hold", 32'hFFFFFFFF);
      xfer("wr4", 1'b1, 10'h004, 32'hCAFEF00D, 32'h0, ERR_EN);
      xfer("rd10", 1'b0, 10'h010, 32'h0, 32'h12345678, ERR_EN);
      idle_check("hold2", ERR_EN ? 32'h0 : 32'h12345678);

      xfer("b2b0", 1'b0, 10'h000, 32'h0, 32'hA5A5A5A5, 1'b0);
      xfer("b2bC", 1'b0, 10'h00C, 32'h0, 32'h0F0F0F0F, 1'b0);
      xfer("mis2", 1'b0, 10'h002, 32'h0, 32'h55AA55AA, ERR_EN);

      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h008; pwdata = 32'h99999999;
      repeat (2) begin
         @(negedge clk);
         check("viol_strb", DW'({wr_en, rd_en, pready}), '0);
         check("viol_addr", DW'(addr), DW'(10'h002));
         check("viol_wdata", wdata, '0);
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;

      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h000; rdata = 32'h13579BDF;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk);
      check("rstmid_pre", DW'(rd_en), DW'(1'b1));
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_strb", DW'({wr_en, rd_en, pready}), '0);
      check("rstmid_addr", DW'(addr), '0);
      check("rstmid_prdata", prdata, '0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      check("rstmid_hold", DW'({wr_en, rd_en, pready}), '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      xfer("wr8", 1'b1, 10'h008, 32'h11223344, 32'h0, 1'b0);
      idle_check("end", 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
